// File: rtl/debounce_multi_if.sv
// Switch bundle: raw switch levels in, debounced level and event pulses out.
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] sw_dbnc;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic [N_CH-1:0] sw_long;
    logic [N_CH-1:0] sw_rep;

    modport master (
        output sw,
        input  sw_dbnc, sw_rise, sw_fall, sw_long, sw_rep
    );

    modport slave (
        input  sw,
        output sw_dbnc, sw_rise, sw_fall, sw_long, sw_rep
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer with edge pulses, long-press detection and
// typematic auto-repeat; every channel is an independent copy of the same slice.
module debounce_multi #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DBNC_CYC = 500000,
    parameter int unsigned HOLD_CYC = 50000000,
    parameter int unsigned REP_CYC  = 10000000,
    parameter bit          REP_EN   = 1'b1,
    parameter bit          RST_VAL  = 1'b0
) (
    input  logic            clk50m,
    input  logic            rst,
    debounce_multi_if.slave bus
);

    localparam int unsigned DW   = $clog2(DBNC_CYC + 1);
    localparam int unsigned HMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_CYC - 1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);
    localparam logic [HW-1:0] HCNT_ONE  = HW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } hold_state_t;

    logic [N_CH-1:0] dbnc_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] long_w;
    logic [N_CH-1:0] rep_w;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic          sync1_q;
            logic          sync2_q;
            logic          dbnc_q;
            logic          rise_q;
            logic          fall_q;
            logic          long_q;
            logic          rep_q;
            logic [DW-1:0] dcnt_q;
            logic [HW-1:0] hcnt_q;
            hold_state_t   state_q;
            logic          accept_d;

            // The synchronised level has disagreed for DBNC_CYC cycles including this one.
            assign accept_d = (sync2_q != dbnc_q) && (dcnt_q == DBNC_LAST);

            always_ff @(posedge clk50m) begin
                if (rst) begin
                    sync1_q <= RST_VAL;
                    sync2_q <= RST_VAL;
                    dbnc_q  <= RST_VAL;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                    long_q  <= 1'b0;
                    rep_q   <= 1'b0;
                    dcnt_q  <= '0;
                    hcnt_q  <= '0;
                    state_q <= ST_IDLE;
                end else begin
                    sync1_q <= bus.sw[gi];
                    sync2_q <= sync1_q;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                    long_q  <= 1'b0;
                    rep_q   <= 1'b0;

                    if (sync2_q == dbnc_q) begin
                        dcnt_q <= '0;
                    end else if (accept_d) begin
                        dcnt_q <= '0;
                        dbnc_q <= sync2_q;
                    end else begin
                        dcnt_q <= dcnt_q + DCNT_ONE;
                    end

                    // A release always wins, so nothing long/repeat can coincide with sw_fall.
                    if (accept_d && !sync2_q) begin
                        fall_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        hcnt_q  <= '0;
                    end else if (accept_d) begin
                        rise_q  <= 1'b1;
                        rep_q   <= REP_EN;
                        state_q <= ST_HOLD;
                        hcnt_q  <= '0;
                    end else begin
                        case (state_q)
                            ST_HOLD: begin
                                if (hcnt_q == HOLD_LAST) begin
                                    long_q  <= 1'b1;
                                    rep_q   <= REP_EN;
                                    state_q <= ST_REPEAT;
                                    hcnt_q  <= '0;
                                end else begin
                                    hcnt_q <= hcnt_q + HCNT_ONE;
                                end
                            end
                            ST_REPEAT: begin
                                if (hcnt_q == REP_LAST) begin
                                    rep_q  <= REP_EN;
                                    hcnt_q <= '0;
                                end else begin
                                    hcnt_q <= hcnt_q + HCNT_ONE;
                                end
                            end
                            default: begin
                                hcnt_q <= '0;
                            end
                        endcase
                    end
                end
            end

            assign dbnc_w[gi] = dbnc_q;
            assign rise_w[gi] = rise_q;
            assign fall_w[gi] = fall_q;
            assign long_w[gi] = long_q;
            assign rep_w[gi]  = rep_q;
        end
    endgenerate

    assign bus.sw_dbnc = dbnc_w;
    assign bus.sw_rise = rise_w;
    assign bus.sw_fall = fall_w;
    assign bus.sw_long = long_w;
    assign bus.sw_rep  = rep_w;

endmodule
